// File: rtl/led_pkg.sv
// Shared mode encodings and small helpers for the LED mode controller.
package led_pkg;

    typedef enum logic [1:0] {
        MODE_OFF        = 2'd0,
        MODE_ON         = 2'd1,
        MODE_BLINK_SLOW = 2'd2,
        MODE_BLINK_FAST = 2'd3
    } mode_t;

    function automatic mode_t next_mode(input mode_t cur);
        case (cur)
            MODE_OFF:        return MODE_ON;
            MODE_ON:         return MODE_BLINK_SLOW;
            MODE_BLINK_SLOW: return MODE_BLINK_FAST;
            default:         return MODE_OFF;
        endcase
    endfunction

    // Counter width for a count range 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/led_mode_ctrl_btn_debounce.sv
// Two-flop synchronizer plus consecutive-cycle debouncer for one raw button.
module btn_debounce
    import led_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int unsigned     CW       = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
        end
    end

    // The count tracks consecutive disagreeing cycles; it can never pass CNT_LAST.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt >= CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
                rise  <= sync2;
                fall  <= ~sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_mode_ctrl.sv
// Button-driven LED mode controller: OFF -> ON -> BLINK_SLOW -> BLINK_FAST -> OFF.
// Define LED_MODE_LONG_PRESS_EN to advance on release and force OFF on a long hold.
module led_mode_ctrl
    import led_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned BLINK_SLOW_HALF = 50_000_000,
    parameter int unsigned BLINK_FAST_HALF = 12_500_000,
    parameter int unsigned LONG_CYCLES     = 200_000_000
) (
    input  logic       clk_100Mhz,
    input  logic       rst,
    input  logic       btn,
    output logic       led,
    output logic [1:0] mode,
    output logic       press_pulse,
    output logic       long_pulse
);

    localparam int unsigned BLINK_MAX = (BLINK_SLOW_HALF > BLINK_FAST_HALF) ?
                                        BLINK_SLOW_HALF : BLINK_FAST_HALF;
    localparam int unsigned   BW        = cnt_w(BLINK_MAX);
    localparam logic [BW-1:0] SLOW_LAST = BW'(BLINK_SLOW_HALF - 1);
    localparam logic [BW-1:0] FAST_LAST = BW'(BLINK_FAST_HALF - 1);

    logic          deb_level;
    logic          deb_fall;
    logic          press_event;
    logic          force_off;
    mode_t         state;
    logic [BW-1:0] blink_cnt;
    logic [BW-1:0] half_last;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk   (clk_100Mhz),
        .rst   (rst),
        .btn   (btn),
        .level (deb_level),
        .rise  (press_pulse),
        .fall  (deb_fall)
    );

`ifdef LED_MODE_LONG_PRESS_EN
    localparam int unsigned   LW        = cnt_w(LONG_CYCLES);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);

    logic [LW-1:0] long_cnt;
    logic          long_seen;

    // long_seen survives into the cycle after release so that release is swallowed.
    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            long_cnt   <= '0;
            long_seen  <= 1'b0;
            long_pulse <= 1'b0;
        end else begin
            long_pulse <= 1'b0;
            if (!deb_level) begin
                long_cnt  <= '0;
                long_seen <= 1'b0;
            end else if (long_cnt < LONG_LAST) begin
                long_cnt <= long_cnt + 1'b1;
            end else if (!long_seen) begin
                long_pulse <= 1'b1;
                long_seen  <= 1'b1;
            end
        end
    end

    assign press_event = deb_fall && !long_seen;
    assign force_off   = long_pulse;
`else
    assign long_pulse  = 1'b0;
    assign press_event = press_pulse;
    assign force_off   = 1'b0;
`endif

    assign half_last = (state == MODE_BLINK_SLOW) ? SLOW_LAST : FAST_LAST;

    // Any mode change restarts the blink phase, so no half-period carries over.
    always_ff @(posedge clk_100Mhz or posedge rst) begin
        if (rst) begin
            state     <= MODE_OFF;
            led       <= 1'b0;
            blink_cnt <= '0;
        end else if (force_off) begin
            state     <= MODE_OFF;
            led       <= 1'b0;
            blink_cnt <= '0;
        end else if (press_event) begin
            state     <= next_mode(state);
            led       <= (next_mode(state) != MODE_OFF);
            blink_cnt <= '0;
        end else begin
            case (state)
                MODE_OFF: begin
                    led       <= 1'b0;
                    blink_cnt <= '0;
                end
                MODE_ON: begin
                    led       <= 1'b1;
                    blink_cnt <= '0;
                end
                default: begin
                    if (blink_cnt >= half_last) begin
                        led       <= ~led;
                        blink_cnt <= '0;
                    end else begin
                        blink_cnt <= blink_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign mode = state;

endmodule

// File: tb/tb_led_mode_ctrl.sv
// Self-checking bench for led_mode_ctrl; behaviour model follows the mode/timing rules.
`timescale 1ns/1ps
module tb_led_mode_ctrl;

    localparam int DEB  = 4;
    localparam int SLOW = 8;
    localparam int FAST = 2;
    localparam int LONG = 20;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn = 1'b0;
    logic       led;
    logic [1:0] mode;
    logic       press_pulse;
    logic       long_pulse;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    led_mode_ctrl #(
        .DEBOUNCE_CYCLES (DEB),
        .BLINK_SLOW_HALF (SLOW),
        .BLINK_FAST_HALF (FAST),
        .LONG_CYCLES     (LONG)
    ) dut (
        .clk_100Mhz  (clk),
        .rst         (rst),
        .btn         (btn),
        .led         (led),
        .mode        (mode),
        .press_pulse (press_pulse),
        .long_pulse  (long_pulse)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit sq[$];
    bit m_deb, m_rise, m_fall, m_fall_long, m_long;
    int m_run, m_held, m_mode, m_age;

    task automatic model_reset();
        sq = '{1'b0, 1'b0};
        m_deb = 0; m_rise = 0; m_fall = 0; m_fall_long = 0; m_long = 0;
        m_run = 0; m_held = 0; m_mode = 0; m_age = 0;
    endtask

    task automatic model_step(input bit b);
        bit o_s2, o_deb, o_rise, o_fall, o_fl, o_long, ev, frc;
        o_s2 = sq[0]; o_deb = m_deb; o_rise = m_rise; o_fall = m_fall;
        o_fl = m_fall_long; o_long = m_long;
        void'(sq.pop_front());
        sq.push_back(b);
        m_rise = 0; m_fall = 0;
        if (o_s2 != o_deb) begin
            m_run++;
            if (m_run == DEB) begin
                m_deb = o_s2; m_run = 0; m_rise = o_s2; m_fall = !o_s2;
            end
        end else begin
            m_run = 0;
        end
        m_held = o_deb ? m_held + 1 : 0;
        m_long = (m_held == LONG);
        if (m_fall) m_fall_long = (m_held >= LONG);
`ifdef LED_MODE_LONG_PRESS_EN
        ev  = o_fall && !o_fl;
        frc = o_long;
`else
        ev  = o_rise;
        frc = 1'b0;
        if (o_fall && o_fl && o_long) ev = o_rise;
`endif
        if (frc) begin
            m_mode = 0; m_age = 0;
        end else if (ev) begin
            m_mode = (m_mode + 1) % 4; m_age = 0;
        end else begin
            m_age++;
        end
    endtask

    function automatic int exp_led();
        case (m_mode)
            0: return 0;
            1: return 1;
            2: return ((m_age / SLOW) % 2 == 0) ? 1 : 0;
            default: return ((m_age / FAST) % 2 == 0) ? 1 : 0;
        endcase
    endfunction

    function automatic int exp_long();
`ifdef LED_MODE_LONG_PRESS_EN
        return int'(m_long);
`else
        return 0;
`endif
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_outputs();
        chk("led",         int'(led),         exp_led());
        chk("mode",        int'(mode),        m_mode);
        chk("press_pulse", int'(press_pulse), int'(m_rise));
        chk("long_pulse",  int'(long_pulse),  exp_long());
    endtask

    task automatic cycle(input bit b);
        btn = b;
        @(posedge clk);
        cyc++;
        model_step(b);
        #1;
        check_outputs();
    endtask

    task automatic press(input int hold, input int gap);
        for (int i = 0; i < hold; i++) cycle(1'b1);
        for (int i = 0; i < gap; i++) cycle(1'b0);
    endtask

    // Asserts rst between edges with btn held as given; releases it off-edge.
    task automatic do_reset(input bit b);
        btn = b;
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_async_led",  int'(led),  0);
        chk("rst_async_mode", int'(mode), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_hold_press", int'(press_pulse), 0);
        chk("rst_hold_long",  int'(long_pulse),  0);
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int base, got, npress, guard, len;
        model_reset();

        // Power-on reset
        repeat (2) @(posedge clk);
        #1;
        chk("reset_led",   int'(led),         0);
        chk("reset_mode",  int'(mode),        0);
        chk("reset_press", int'(press_pulse), 0);
        chk("reset_long",  int'(long_pulse),  0);
        #2;
        rst = 1'b0;
        repeat (3) cycle(1'b0);

        // Glitch high-low-high, 3 cycles each, must be ignored
        npress = 0;
        for (int i = 0; i < 9; i++) begin
            cycle((i / 3) != 1);
            if (press_pulse) npress++;
        end
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0);
            if (press_pulse) npress++;
        end
        chk("glitch_no_press", npress, 0);
        chk("glitch_mode",     int'(mode), 0);

        // Clean rise: pulse 2+DEB cycles later, one cycle wide
        base = cyc;
        got  = -1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1);
            if (press_pulse && got < 0) got = cyc;
        end
        chk("press_latency", got - base, DEB + 2);
        for (int i = 0; i < 10; i++) cycle(1'b0);
        chk("press1_mode", int'(mode), 1);
        chk("press1_led",  int'(led),  1);

        // Remaining presses walk through the blink modes
        press(8, 30);
        chk("press2_mode", int'(mode), 2);
        press(8, 20);
        chk("press3_mode", int'(mode), 3);
        press(8, 12);
        chk("press4_mode", int'(mode), 0);
        chk("press4_led",  int'(led),  0);

`ifdef LED_MODE_LONG_PRESS_EN
        // Long hold in BLINK_FAST forces OFF; its release does not advance
        guard = 0;
        while (m_mode != 3 && guard < 8) begin press(8, 12); guard++; end
        chk("long_setup_mode", int'(mode), 3);
        base = -1; got = -1;
        for (int i = 0; i < 30; i++) begin
            cycle(1'b1);
            if (press_pulse && base < 0) base = cyc;
            if (long_pulse && got < 0) begin
                got = cyc;
                cycle(1'b1);
                i++;
                chk("long_next_mode", int'(mode), 0);
            end
        end
        chk("long_latency", got - base, LONG);
        for (int i = 0; i < 15; i++) cycle(1'b0);
        chk("long_release_mode", int'(mode), 0);
`endif

        // Reset mid-BLINK_FAST and mid-debounce with the button held
        guard = 0;
        while (m_mode != 3 && guard < 8) begin press(8, 12); guard++; end
        chk("rstblink_setup_mode", int'(mode), 3);
        cycle(1'b1);
        cycle(1'b1);
        cycle(1'b1);
        do_reset(1'b1);
        base = cyc;
        got  = -1;
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1);
            if (press_pulse && got < 0) got = cyc;
        end
        chk("rst_release_latency", got - base, DEB + 2);
        for (int i = 0; i < 10; i++) cycle(1'b0);
        chk("rst_release_mode", int'(mode), 1);

        // Randomized button activity
        for (int n = 0; n < 80; n++) begin
`ifdef LED_MODE_LONG_PRESS_EN
            len = $urandom_range(1, 30);
`else
            len = $urandom_range(1, 12);
`endif
            for (int i = 0; i < len; i++) cycle(n[0]);
        end
        for (int i = 0; i < 20; i++) cycle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1, "simulation time limit");
    end

endmodule
